// File: rtl/fetch_entry_queue.sv
// fetch_entry_queue: DEPTH-entry FIFO between the frontend and the decode stage.
// Optional feature: define FETCH_QUEUE_BYPASS_EN to forward a push straight to
// the output when the queue is empty and decode is ready (zero-latency path).

package ariane_pkg;
   typedef struct packed {
      logic [63:0] address;
      logic [31:0] instruction;
      logic        branch_taken;
   } fetch_entry_t;
endpackage

module fetch_entry_queue #(
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   input  ariane_pkg::fetch_entry_t push_entry_i,
   input  logic                     push_valid_i,
   output logic                     push_ready_o,
   output ariane_pkg::fetch_entry_t fetch_entry_o,
   output logic                     fetch_entry_valid_o,
   input  logic                     fetch_entry_ready_i,
   output logic [$clog2(DEPTH):0]   occupancy_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   ariane_pkg::fetch_entry_t mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0]   count;
   logic          bypass, push, pop, push_st, pop_st;

`ifdef FETCH_QUEUE_BYPASS_EN
   assign bypass = (count == '0) && push_valid_i && fetch_entry_ready_i && !flush_i;
`else
   assign bypass = 1'b0;
`endif

   // a pop while full does not open a slot in the same cycle
   assign push_ready_o        = (count < FULL) && !flush_i;
   assign fetch_entry_valid_o = ((count != '0) || bypass) && !flush_i;
   assign fetch_entry_o       = bypass ? push_entry_i : mem[rd_ptr];
   assign occupancy_o         = count;
   assign push                = push_valid_i && push_ready_o;
   assign pop                 = fetch_entry_valid_o && fetch_entry_ready_i;
   // a forwarded entry is consumed directly and never touches storage
   assign push_st             = push && !bypass;
   assign pop_st              = pop && !bypass;

   // pointer and count bookkeeping; flush clears them but leaves storage alone
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         rd_ptr <= rd_ptr + AW'(pop_st);
         wr_ptr <= wr_ptr + AW'(push_st);
         count  <= count + (AW+1)'(push_st) - (AW+1)'(pop_st);
      end

   // entry storage, written on accepted non-forwarded pushes
   always_ff @(posedge clk_i)
      if (push_st) mem[wr_ptr] <= push_entry_i;

endmodule

// File: tb/tb_fetch_entry_queue.sv
// tb_fetch_entry_queue: directed self-checking bench for fetch_entry_queue.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_fetch_entry_queue;
   import ariane_pkg::*;

   localparam int DEPTH = 4;

   logic         clk_i = 1'b0;
   logic         rst_ni, flush_i, push_valid, push_ready, fetch_valid, fetch_ready;
   fetch_entry_t push_entry, fetch_entry;
   logic [2:0]   occupancy;
   int           n_checks = 0, n_pass = 0;

   fetch_entry_queue #(.DEPTH(DEPTH)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
      .push_entry_i(push_entry), .push_valid_i(push_valid), .push_ready_o(push_ready),
      .fetch_entry_o(fetch_entry), .fetch_entry_valid_o(fetch_valid),
      .fetch_entry_ready_i(fetch_ready), .occupancy_o(occupancy)
   );

   always #5 clk_i = ~clk_i;

   function automatic fetch_entry_t mk(input int n);
      fetch_entry_t e;
      e.address      = 64'h8000_0000 + 64'(n) * 4;
      e.instruction  = 32'hDEAD_0000 ^ 32'(n);
      e.branch_taken = n[0];
      return e;
   endfunction

   task automatic test_reset();
      rst_ni = 1'b0; flush_i = 1'b0; push_valid = 1'b0; fetch_ready = 1'b0; push_entry = mk(0);
      #3;
      n_checks++; if (fetch_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", fetch_valid); else n_pass++;
      n_checks++; if (push_ready !== 1'b1) $display("FAIL reset_push_ready got %b want 1", push_ready); else n_pass++;
      n_checks++; if (occupancy !== 3'd0) $display("FAIL reset_occ got %0d want 0", occupancy); else n_pass++;
      @(negedge clk_i);
      rst_ni = 1'b1;
      #1;
      n_checks++; if (occupancy !== 3'd0) $display("FAIL reset_release_occ got %0d want 0", occupancy); else n_pass++;
      @(negedge clk_i);
   endtask

   task automatic test_fill();
      fetch_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         push_valid = 1'b1; push_entry = mk(1 + i);
         #1;
         n_checks++; if (push_ready !== 1'b1) $display("FAIL fill_push_ready[%0d] got %b want 1", i, push_ready); else n_pass++;
         if (i == 0) begin
            n_checks++; if (fetch_valid !== 1'b0) $display("FAIL fill_first_valid got %b want 0", fetch_valid); else n_pass++;
         end
         @(negedge clk_i);
      end
      push_valid = 1'b0;
      #1;
      n_checks++; if (occupancy !== 3'd4) $display("FAIL fill_occ got %0d want 4", occupancy); else n_pass++;
      n_checks++; if (push_ready !== 1'b0) $display("FAIL fill_push_ready_full got %b want 0", push_ready); else n_pass++;
      n_checks++; if (fetch_valid !== 1'b1) $display("FAIL fill_valid got %b want 1", fetch_valid); else n_pass++;
      n_checks++; if (fetch_entry !== mk(1)) $display("FAIL fill_head got %h want %h", fetch_entry, mk(1)); else n_pass++;
      @(negedge clk_i);
   endtask

   task automatic test_full_push();
      fetch_entry_t exp [3];
      exp[0] = mk(3); exp[1] = mk(4); exp[2] = mk(5);
      push_valid = 1'b1; push_entry = mk(5); fetch_ready = 1'b1;
      #1;
      n_checks++; if (push_ready !== 1'b0) $display("FAIL full_reject got %b want 0", push_ready); else n_pass++;
      n_checks++; if (fetch_entry !== mk(1)) $display("FAIL full_pop_a got %h want %h", fetch_entry, mk(1)); else n_pass++;
      @(negedge clk_i);
      #1;
      n_checks++; if (occupancy !== 3'd3) $display("FAIL full_occ_after_pop got %0d want 3", occupancy); else n_pass++;
      n_checks++; if (push_ready !== 1'b1) $display("FAIL full_accept_e got %b want 1", push_ready); else n_pass++;
      n_checks++; if (fetch_entry !== mk(2)) $display("FAIL full_head_b got %h want %h", fetch_entry, mk(2)); else n_pass++;
      @(negedge clk_i);
      push_valid = 1'b0;
      #1;
      n_checks++; if (occupancy !== 3'd3) $display("FAIL full_occ_push_pop got %0d want 3", occupancy); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) #1;
         n_checks++; if (fetch_valid !== 1'b1 || fetch_entry !== exp[i]) $display("FAIL full_drain[%0d] got %b/%h want 1/%h", i, fetch_valid, fetch_entry, exp[i]); else n_pass++;
         @(negedge clk_i);
      end
      fetch_ready = 1'b0;
      #1;
      n_checks++; if (fetch_valid !== 1'b0 || occupancy !== 3'd0) $display("FAIL full_empty got %b/%0d want 0/0", fetch_valid, occupancy); else n_pass++;
      @(negedge clk_i);
   endtask

   task automatic test_stream();
      int got = 0;
      bit over = 1'b0;
      fetch_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         push_valid = (i < 10); push_entry = mk(100 + i);
         #1;
         if (fetch_valid) begin
            n_checks++; if (fetch_entry !== mk(100 + got)) $display("FAIL stream_order[%0d] got %h want %h", got, fetch_entry, mk(100 + got)); else n_pass++;
            got++;
         end
         if (occupancy > 3'd4) over = 1'b1;
         @(negedge clk_i);
      end
      push_valid = 1'b0;
      #1;
      n_checks++; if (got !== 10) $display("FAIL stream_count got %0d want 10", got); else n_pass++;
      n_checks++; if (over !== 1'b0) $display("FAIL stream_occ_bound got %b want 0", over); else n_pass++;
      n_checks++; if (occupancy !== 3'd0) $display("FAIL stream_occ_end got %0d want 0", occupancy); else n_pass++;
      fetch_ready = 1'b0;
      @(negedge clk_i);
   endtask

   task automatic test_flush();
      fetch_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         push_valid = 1'b1; push_entry = mk(20 + i);
         @(negedge clk_i);
      end
      flush_i = 1'b1; push_entry = mk(99);
      #1;
      n_checks++; if (fetch_valid !== 1'b0) $display("FAIL flush_valid got %b want 0", fetch_valid); else n_pass++;
      n_checks++; if (push_ready !== 1'b0) $display("FAIL flush_push_ready got %b want 0", push_ready); else n_pass++;
      @(negedge clk_i);
      flush_i = 1'b0; push_valid = 1'b0;
      #1;
      n_checks++; if (occupancy !== 3'd0) $display("FAIL flush_occ got %0d want 0", occupancy); else n_pass++;
      n_checks++; if (fetch_valid !== 1'b0) $display("FAIL flush_after_valid got %b want 0", fetch_valid); else n_pass++;
      @(negedge clk_i);
      push_valid = 1'b1; push_entry = mk(30);
      @(negedge clk_i);
      push_valid = 1'b0;
      #1;
      n_checks++; if (fetch_entry !== mk(30)) $display("FAIL flush_next_entry got %h want %h", fetch_entry, mk(30)); else n_pass++;
      n_checks++; if (occupancy !== 3'd1) $display("FAIL flush_next_occ got %0d want 1", occupancy); else n_pass++;
      fetch_ready = 1'b1;
      @(negedge clk_i);
      #1;
      n_checks++; if (fetch_valid !== 1'b0 || occupancy !== 3'd0) $display("FAIL flush_drain got %b/%0d want 0/0", fetch_valid, occupancy); else n_pass++;
      fetch_ready = 1'b0;
      @(negedge clk_i);
   endtask

   task automatic test_latency();
      push_valid = 1'b1; push_entry = mk(40); fetch_ready = 1'b1;
      #1;
`ifdef FETCH_QUEUE_BYPASS_EN
      n_checks++; if (fetch_valid !== 1'b1 || fetch_entry !== mk(40)) $display("FAIL bypass_same_cycle got %b/%h want 1/%h", fetch_valid, fetch_entry, mk(40)); else n_pass++;
`else
      n_checks++; if (fetch_valid !== 1'b0) $display("FAIL latency_same_cycle got %b want 0", fetch_valid); else n_pass++;
`endif
      n_checks++; if (occupancy !== 3'd0) $display("FAIL latency_occ0 got %0d want 0", occupancy); else n_pass++;
      @(negedge clk_i);
      push_valid = 1'b0;
      #1;
`ifdef FETCH_QUEUE_BYPASS_EN
      n_checks++; if (fetch_valid !== 1'b0 || occupancy !== 3'd0) $display("FAIL bypass_next got %b/%0d want 0/0", fetch_valid, occupancy); else n_pass++;
`else
      n_checks++; if (fetch_valid !== 1'b1 || fetch_entry !== mk(40)) $display("FAIL latency_next got %b/%h want 1/%h", fetch_valid, fetch_entry, mk(40)); else n_pass++;
      n_checks++; if (occupancy !== 3'd1) $display("FAIL latency_occ1 got %0d want 1", occupancy); else n_pass++;
`endif
      @(negedge clk_i);
      #1;
      n_checks++; if (fetch_valid !== 1'b0 || occupancy !== 3'd0) $display("FAIL latency_end got %b/%0d want 0/0", fetch_valid, occupancy); else n_pass++;
      fetch_ready = 1'b0;
      @(negedge clk_i);
   endtask

   task automatic test_async_reset();
      fetch_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         push_valid = 1'b1; push_entry = mk(50 + i);
         @(negedge clk_i);
      end
      push_valid = 1'b0;
      #1;
      n_checks++; if (occupancy !== 3'd2) $display("FAIL areset_pre_occ got %0d want 2", occupancy); else n_pass++;
      #1 rst_ni = 1'b0;
      #1;
      n_checks++; if (fetch_valid !== 1'b0) $display("FAIL areset_valid got %b want 0", fetch_valid); else n_pass++;
      n_checks++; if (occupancy !== 3'd0) $display("FAIL areset_occ got %0d want 0", occupancy); else n_pass++;
      n_checks++; if (push_ready !== 1'b1) $display("FAIL areset_push_ready got %b want 1", push_ready); else n_pass++;
      #1 rst_ni = 1'b1;
      @(negedge clk_i);
      #1;
      n_checks++; if (fetch_valid !== 1'b0 || occupancy !== 3'd0) $display("FAIL areset_after got %b/%0d want 0/0", fetch_valid, occupancy); else n_pass++;
      push_valid = 1'b1; push_entry = mk(60);
      @(negedge clk_i);
      push_valid = 1'b0;
      #1;
      n_checks++; if (fetch_entry !== mk(60) || occupancy !== 3'd1) $display("FAIL areset_reuse got %h/%0d want %h/1", fetch_entry, occupancy, mk(60)); else n_pass++;
      @(negedge clk_i);
   endtask

   initial begin
      test_reset();
      test_fill();
      test_full_push();
      test_stream();
      test_flush();
      test_latency();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
